// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered ack/err handshakes, programmable thresholds and occupancy count.
// Optional high-water mark (peak, peak_clr) is built when SYNC_FIFO_PEAK_EN is defined.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 15,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    input  logic                     rd_en,
`ifdef SYNC_FIFO_PEAK_EN
    input  logic                     peak_clr,
    output logic [$clog2(DEPTH):0]   peak,
`endif
    output logic [WIDTH-1:0]         dout,
    output logic                     wr_ack,
    output logic                     wr_err,
    output logic                     rd_ack,
    output logic                     rd_err,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_ok, rd_ok;

    // Acceptance looks only at the registered count, so both-at-boundary cases fall out naturally.
    assign wr_ok = wr_en && (count != DEPTH_C);
    assign rd_ok = rd_en && (count != '0);

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok)
            count_nxt = count + 1'b1;
        else if (!wr_ok && rd_ok)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clear && wr_ok)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            dout   <= '0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            rd_ack <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            count  <= count_nxt;
            wr_ack <= wr_ok;
            wr_err <= wr_en && !wr_ok;
            rd_ack <= rd_ok;
            rd_err <= rd_en && !rd_ok;
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok) begin
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign empty        = (count == '0);
    assign almost_empty = (count <= AE_C);

`ifdef SYNC_FIFO_PEAK_EN
    // peak_clr wins over the max update so software can re-arm the mark at the current level.
    always_ff @(posedge clk) begin
        if (clear)
            peak <= '0;
        else if (peak_clr)
            peak <= count_nxt;
        else if (count_nxt > peak)
            peak <= count_nxt;
    end
`else
    // default build carries no high-water tracking
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: vector table for fill/drain/boundaries, hand sequences for wrap and clear.
module tb_sync_fifo_param;
    logic       clk;
    logic       clear;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       wr_ack, wr_err, rd_ack, rd_err;
    logic       full, almost_full, empty, almost_empty;
    logic [4:0] count;
`ifdef SYNC_FIFO_PEAK_EN
    logic       peak_clr;
    logic [4:0] peak;
`endif

    int total = 0;
    int bad   = 0;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(15), .AE_THRESH(1)) dut (
        .clk(clk),
        .clear(clear),
        .din(din),
        .wr_en(wr_en),
        .rd_en(rd_en),
`ifdef SYNC_FIFO_PEAK_EN
        .peak_clr(peak_clr),
        .peak(peak),
`endif
        .dout(dout),
        .wr_ack(wr_ack),
        .wr_err(wr_err),
        .rd_ack(rd_ack),
        .rd_err(rd_err),
        .full(full),
        .almost_full(almost_full),
        .empty(empty),
        .almost_empty(almost_empty),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr, we, re;
        logic [7:0] d;
        logic [4:0] cnt;
        logic [7:0] dout;
        logic       wa, werr, ra, rerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic clr, logic we, logic re, logic [7:0] d, logic [4:0] cnt,
                                logic [7:0] dv, logic wa, logic werr, logic ra, logic rerr);
        vec_t v;
        v.clr = clr; v.we = we; v.re = re; v.d = d; v.cnt = cnt; v.dout = dv;
        v.wa = wa; v.werr = werr; v.ra = ra; v.rerr = rerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, then check the registered results just after the edge.
    task automatic step(input string nm, input vec_t v);
        clear = v.clr; wr_en = v.we; rd_en = v.re; din = v.d;
        @(posedge clk);
        #1;
        chk({nm, ".count"}, 32'(count), 32'(v.cnt));
        chk({nm, ".dout"}, 32'(dout), 32'(v.dout));
        chk({nm, ".wr_ack"}, 32'(wr_ack), 32'(v.wa));
        chk({nm, ".wr_err"}, 32'(wr_err), 32'(v.werr));
        chk({nm, ".rd_ack"}, 32'(rd_ack), 32'(v.ra));
        chk({nm, ".rd_err"}, 32'(rd_err), 32'(v.rerr));
        chk({nm, ".full"}, 32'(full), 32'(v.cnt == 5'd16));
        chk({nm, ".almost_full"}, 32'(almost_full), 32'(v.cnt >= 5'd15));
        chk({nm, ".empty"}, 32'(empty), 32'(v.cnt == 5'd0));
        chk({nm, ".almost_empty"}, 32'(almost_empty), 32'(v.cnt <= 5'd1));
    endtask

    initial begin
        clear = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
`ifdef SYNC_FIFO_PEAK_EN
        peak_clr = 1'b0;
`endif
        // reset, fill to full, overflow, drain, underflow
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 1, 0, 8'(i), 5'(i + 1), 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hEE, 16, 8'h00, 0, 1, 0, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 0, 1, 8'h00, 5'(15 - i), 8'(i), 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h0F, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h0F, 0, 0, 0, 0));
        // simultaneous read/write at full and at empty
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 1, 0, 8'(8'h30 + i), 5'(i + 1), 8'h0F, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h55, 15, 8'h30, 0, 1, 1, 0));
        for (int i = 1; i < 16; i++)
            tbl.push_back(mk(0, 0, 1, 8'h00, 5'(15 - i), 8'(8'h30 + i), 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h66, 1, 8'h3F, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 8'h66, 0, 0, 1, 0));

        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i]);

        // wrap-around: move pointers forward, then stream through the wrap point
        for (int i = 0; i < 10; i++)
            step($sformatf("wfill%0d", i), mk(0, 1, 0, 8'(8'h10 + i), 5'(i + 1), 8'h66, 1, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            step($sformatf("wdrain%0d", i), mk(0, 0, 1, 8'h00, 5'(9 - i), 8'(8'h10 + i), 0, 0, 1, 0));
        step("wrap0", mk(0, 1, 0, 8'hA0, 1, 8'h19, 1, 0, 0, 0));
        for (int k = 1; k < 12; k++)
            step($sformatf("wrap%0d", k), mk(0, 1, 1, 8'(8'hA0 + k), 1, 8'(8'hA0 + k - 1), 1, 0, 1, 0));
        step("wrap_last", mk(0, 0, 1, 8'h00, 0, 8'hAB, 0, 0, 1, 0));

        // clear in the middle of traffic overrides both requests
        for (int i = 0; i < 7; i++)
            step($sformatf("cfill%0d", i), mk(0, 1, 0, 8'(8'h70 + i), 5'(i + 1), 8'hAB, 1, 0, 0, 0));
        step("mid_clear", mk(1, 1, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 0));
        step("post_clear", mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0));

`ifdef SYNC_FIFO_PEAK_EN
        chk("peak_after_clear", 32'(peak), 32'd0);
        for (int i = 0; i < 16; i++)
            step($sformatf("pfill%0d", i), mk(0, 1, 0, 8'(8'h80 + i), 5'(i + 1), 8'h00, 1, 0, 0, 0));
        chk("peak_full", 32'(peak), 32'd16);
        peak_clr = 1'b1;
        step("peak_clr_rd", mk(0, 0, 1, 8'h00, 15, 8'h80, 0, 0, 1, 0));
        chk("peak_reloaded", 32'(peak), 32'd15);
        peak_clr = 1'b0;
        step("peak_refill", mk(0, 1, 0, 8'hC0, 16, 8'h80, 1, 0, 0, 0));
        chk("peak_regrow", 32'(peak), 32'd16);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
